// File: rtl/ddr_tx_pkg.sv
// Shared types and constants for the DDR transmit sequencer.
// The optional parity cycle is enabled by defining DDR_TX_PARITY_EN.
package ddr_tx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_PREAMBLE = 3'd1,
        ST_SHIFT    = 3'd2,
        ST_PARITY   = 3'd3,
        ST_GAP      = 3'd4
    } state_e;

    localparam logic PREAMBLE_D0 = 1'b1;
    localparam logic PREAMBLE_D1 = 1'b0;

    // Counter must hold the longest state length; at least one bit wide.
    function automatic int cnt_width(input int pre_len, input int shift_len, input int gap_len);
        int m;
        m = pre_len;
        if (shift_len > m) begin
            m = shift_len;
        end
        if (gap_len > m) begin
            m = gap_len;
        end
        return (m < 1) ? 1 : $clog2(m + 1);
    endfunction

endpackage

// File: rtl/ddr_tx_oddr_pair.sv
// Behavioural equivalent of the data and forwarded-clock ODDR2 pair (C0 = clk, C1 = ~clk, R = S = 0).
// Belongs in the top-level I/O wrapper; kept behavioural so the bundle simulates without unisims.
module ddr_tx_oddr_pair (
    input  logic clk,
    input  logic data_d0,
    input  logic data_d1,
    input  logic data_ce,
    input  logic clk_d0,
    input  logic clk_d1,
    output logic ddr_q,
    output logic clk_q
);

    logic data_rise_q;
    logic data_fall_q;
    logic clk_rise_q;
    logic clk_fall_q;

    // D0 is captured on the C0 (rising clk) edge.
    always_ff @(posedge clk) begin
        if (data_ce) begin
            data_rise_q <= data_d0;
        end else begin
            data_rise_q <= data_rise_q;
        end
        clk_rise_q <= clk_d0;
    end

    // D1 is captured on the C1 (falling clk) edge.
    always_ff @(negedge clk) begin
        if (data_ce) begin
            data_fall_q <= data_d1;
        end else begin
            data_fall_q <= data_fall_q;
        end
        clk_fall_q <= clk_d1;
    end

    assign ddr_q = clk ? data_rise_q : data_fall_q;
    assign clk_q = clk ? clk_rise_q  : clk_fall_q;

endmodule

// File: rtl/ddr_tx_sequencer.sv
// Single-lane DDR transmit sequencer: preamble, word MSB-first two bits per clock, gap.
// Define DDR_TX_PARITY_EN to append a parity cycle after the data bits.
module ddr_tx_sequencer
    import ddr_tx_pkg::*;
#(
    parameter int   DATA_WIDTH      = 16,
    parameter int   PREAMBLE_CYCLES = 2,
    parameter int   GAP_CYCLES      = 1,
    parameter logic IDLE_LEVEL      = 1'b0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic                  ddr_d0,
    output logic                  ddr_d1,
    output logic                  ddr_ce,
    output logic                  clk_d0,
    output logic                  clk_d1,
    output logic                  frame,
    output logic                  busy
);

    localparam int SHIFT_CYCLES = DATA_WIDTH / 2;
    localparam int CW = cnt_width(PREAMBLE_CYCLES, SHIFT_CYCLES, GAP_CYCLES);
    localparam logic [CW-1:0] PRE_LOAD   = CW'((PREAMBLE_CYCLES > 0) ? PREAMBLE_CYCLES - 1 : 0);
    localparam logic [CW-1:0] SHIFT_LOAD = CW'(SHIFT_CYCLES - 1);
    localparam logic [CW-1:0] GAP_LOAD   = CW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    state_e                state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] sr_q, sr_d;
`ifdef DDR_TX_PARITY_EN
    logic                  par_q, par_d;
`endif
    logic in_ready_q, in_ready_d;
    logic ddr_d0_q, ddr_d0_d;
    logic ddr_d1_q, ddr_d1_d;
    logic ddr_ce_q, ddr_ce_d;
    logic clk_d0_q, clk_d0_d;
    logic clk_d1_q, clk_d1_d;
    logic frame_q, frame_d;
    logic busy_q, busy_d;

    logic          accept_s;
    state_e        tail_state_s;
    logic [CW-1:0] tail_cnt_s;

    assign accept_s = in_valid && in_ready_q;

    // Next state, counter and data path; the tail is where a frame goes once its bits are out.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sr_d    = sr_q;
`ifdef DDR_TX_PARITY_EN
        par_d   = par_q;
`endif
        if (GAP_CYCLES > 0) begin
            tail_state_s = ST_GAP;
            tail_cnt_s   = GAP_LOAD;
        end else begin
            tail_state_s = ST_IDLE;
            tail_cnt_s   = {CW{1'b0}};
        end

        case (state_q)
            ST_IDLE: begin
                if (accept_s) begin
                    sr_d = in_data;
`ifdef DDR_TX_PARITY_EN
                    par_d = ^in_data;
`endif
                    if (PREAMBLE_CYCLES > 0) begin
                        state_d = ST_PREAMBLE;
                        cnt_d   = PRE_LOAD;
                    end else begin
                        state_d = ST_SHIFT;
                        cnt_d   = SHIFT_LOAD;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_PREAMBLE: begin
                if (cnt_q == {CW{1'b0}}) begin
                    state_d = ST_SHIFT;
                    cnt_d   = SHIFT_LOAD;
                end else begin
                    cnt_d = cnt_q - CW'(1'b1);
                end
            end
            ST_SHIFT: begin
                sr_d = sr_q << 2;
                if (cnt_q == {CW{1'b0}}) begin
`ifdef DDR_TX_PARITY_EN
                    state_d = ST_PARITY;
                    cnt_d   = {CW{1'b0}};
`else
                    state_d = tail_state_s;
                    cnt_d   = tail_cnt_s;
`endif
                end else begin
                    cnt_d = cnt_q - CW'(1'b1);
                end
            end
`ifdef DDR_TX_PARITY_EN
            ST_PARITY: begin
                state_d = tail_state_s;
                cnt_d   = tail_cnt_s;
            end
`endif
            ST_GAP: begin
                if (cnt_q == {CW{1'b0}}) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - CW'(1'b1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = {CW{1'b0}};
            end
        endcase
    end

    // Output levels follow the current state and land in flops one cycle later.
    always_comb begin
        ddr_d0_d   = IDLE_LEVEL;
        ddr_d1_d   = IDLE_LEVEL;
        ddr_ce_d   = 1'b1;
        clk_d0_d   = 1'b0;
        clk_d1_d   = 1'b0;
        frame_d    = 1'b0;
        busy_d     = 1'b1;
        in_ready_d = (state_d == ST_IDLE);
        case (state_q)
            ST_IDLE: begin
                busy_d = 1'b0;
            end
            ST_PREAMBLE: begin
                ddr_d0_d = PREAMBLE_D0;
                ddr_d1_d = PREAMBLE_D1;
                clk_d0_d = 1'b1;
            end
            ST_SHIFT: begin
                ddr_d0_d = sr_q[DATA_WIDTH-1];
                ddr_d1_d = sr_q[DATA_WIDTH-2];
                clk_d0_d = 1'b1;
                frame_d  = 1'b1;
            end
`ifdef DDR_TX_PARITY_EN
            ST_PARITY: begin
                ddr_d0_d = par_q;
                ddr_d1_d = ~par_q;
                clk_d0_d = 1'b1;
                frame_d  = 1'b1;
            end
`endif
            ST_GAP: begin
                busy_d = 1'b1;
            end
            default: begin
                busy_d = 1'b0;
            end
        endcase
    end

    // State and output registers; reset drops any in-flight word.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            cnt_q      <= {CW{1'b0}};
            sr_q       <= {DATA_WIDTH{1'b0}};
`ifdef DDR_TX_PARITY_EN
            par_q      <= 1'b0;
`endif
            in_ready_q <= 1'b0;
            ddr_d0_q   <= IDLE_LEVEL;
            ddr_d1_q   <= IDLE_LEVEL;
            ddr_ce_q   <= 1'b1;
            clk_d0_q   <= 1'b0;
            clk_d1_q   <= 1'b0;
            frame_q    <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            sr_q       <= sr_d;
`ifdef DDR_TX_PARITY_EN
            par_q      <= par_d;
`endif
            in_ready_q <= in_ready_d;
            ddr_d0_q   <= ddr_d0_d;
            ddr_d1_q   <= ddr_d1_d;
            ddr_ce_q   <= ddr_ce_d;
            clk_d0_q   <= clk_d0_d;
            clk_d1_q   <= clk_d1_d;
            frame_q    <= frame_d;
            busy_q     <= busy_d;
        end
    end

    assign in_ready = in_ready_q;
    assign ddr_d0   = ddr_d0_q;
    assign ddr_d1   = ddr_d1_q;
    assign ddr_ce   = ddr_ce_q;
    assign clk_d0   = clk_d0_q;
    assign clk_d1   = clk_d1_q;
    assign frame    = frame_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_ddr_tx_sequencer.sv
// Bench for ddr_tx_sequencer: directed tables and sequences plus random traffic against a frame-level model.
module tb_ddr_tx_sequencer;

`ifdef DDR_TX_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif

    typedef struct packed {
        logic d0; logic d1; logic fr; logic bz; logic cd0; logic cd1; logic ce; logic rdy;
    } obs_t;

    typedef struct packed {
        int         left;
        int         pos;
        logic [7:0] word;
        obs_t       exp;
    } mdl_t;

    typedef struct {
        logic v; logic [7:0] d;
        logic d0; logic d1; logic fr; logic bz; logic cd0; logic rdy;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       va, vb;
    logic [7:0] da, db;
    logic a_rdy, a_d0, a_d1, a_ce, a_cd0, a_cd1, a_fr, a_bz;
    logic b_rdy, b_d0, b_d1, b_ce, b_cd0, b_cd1, b_fr, b_bz;
    logic a_ddr_q, a_clk_q;

    int   n_tests = 0;
    int   n_fail  = 0;
    logic chk_en  = 1'b0;
    mdl_t ma = '0;
    mdl_t mb = '0;

    logic cap_fr [64];
    logic cap_d0 [64];
    logic cap_d1 [64];
    logic cap_cd0[64];
    int   cap_n;

    ddr_tx_sequencer #(.DATA_WIDTH(8), .PREAMBLE_CYCLES(2), .GAP_CYCLES(1), .IDLE_LEVEL(1'b0)) dut_a (
        .clk(clk), .reset(rst), .in_data(da), .in_valid(va), .in_ready(a_rdy),
        .ddr_d0(a_d0), .ddr_d1(a_d1), .ddr_ce(a_ce), .clk_d0(a_cd0), .clk_d1(a_cd1),
        .frame(a_fr), .busy(a_bz)
    );

    ddr_tx_sequencer #(.DATA_WIDTH(8), .PREAMBLE_CYCLES(0), .GAP_CYCLES(0), .IDLE_LEVEL(1'b1)) dut_b (
        .clk(clk), .reset(rst), .in_data(db), .in_valid(vb), .in_ready(b_rdy),
        .ddr_d0(b_d0), .ddr_d1(b_d1), .ddr_ce(b_ce), .clk_d0(b_cd0), .clk_d1(b_cd1),
        .frame(b_fr), .busy(b_bz)
    );

    ddr_tx_oddr_pair u_pair (
        .clk(clk), .data_d0(a_d0), .data_d1(a_d1), .data_ce(a_ce),
        .clk_d0(a_cd0), .clk_d1(a_cd1), .ddr_q(a_ddr_q), .clk_q(a_clk_q)
    );

    function automatic obs_t idle_obs(input logic idl);
        obs_t o;
        o = {idl, idl, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        return o;
    endfunction

    // Line contents for cycle i of a frame: preamble, data pairs MSB first, optional parity, gap.
    function automatic obs_t frame_obs(input int p, input logic idl, input logic [7:0] w, input int i);
        obs_t o;
        int   k;
        o = {idl, idl, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        if (i < p) begin
            o.d0 = 1'b1; o.d1 = 1'b0; o.cd0 = 1'b1;
        end else if (i < p + 4) begin
            k = i - p;
            o.d0 = w[7 - 2 * k]; o.d1 = w[6 - 2 * k]; o.fr = 1'b1; o.cd0 = 1'b1;
        end else if (PAR == 1 && i == p + 4) begin
            o.d0 = ^w; o.d1 = ~(^w); o.fr = 1'b1; o.cd0 = 1'b1;
        end
        return o;
    endfunction

    function automatic mdl_t step(input mdl_t m, input logic r, input logic v, input logic [7:0] d,
                                  input int p, input int g, input logic idl);
        mdl_t n;
        logic acc;
        n = m;
        if (r) begin
            n.left = 0; n.pos = 0; n.exp = idle_obs(idl);
        end else begin
            acc = v && m.exp.rdy;
            if (m.left > 0) begin
                n.exp  = frame_obs(p, idl, m.word, m.pos);
                n.pos  = m.pos + 1;
                n.left = m.left - 1;
            end else begin
                n.exp = idle_obs(idl);
            end
            if (acc) begin
                n.left = p + 4 + PAR + g; n.pos = 0; n.word = d;
            end
            n.exp.rdy = (n.left == 0);
        end
        return n;
    endfunction

    function automatic logic [9:0] exp_pairs(input logic [7:0] w);
        if (PAR == 1) begin
            return {w, ^w, ~(^w)};
        end
        return {2'b00, w};
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready_a();
        int c;
        c = 0;
        while (!a_rdy && c < 50) begin
            tick();
            c++;
        end
        check("wait_ready_a", {31'd0, a_rdy}, 32'd1);
    endtask

    // Sends nw words (w1, then w2) on dut_a with valid held, recording the line for 40 cycles.
    task automatic capture(input logic [7:0] w1, input logic [7:0] w2, input int nw);
        int   acc_cnt;
        logic acc;
        acc_cnt = 0; va = 1'b1; da = w1; cap_n = 0;
        for (int c = 0; c < 40; c++) begin
            acc = a_rdy && va;
            tick();
            cap_fr[c] = a_fr; cap_d0[c] = a_d0; cap_d1[c] = a_d1; cap_cd0[c] = a_cd0;
            cap_n = c + 1;
            if (acc) begin
                acc_cnt++;
                if (acc_cnt < nw) da = w2;
                else va = 1'b0;
            end
        end
        va = 1'b0;
        check("accept_count", acc_cnt, nw);
    endtask

    task automatic run_info(input int run, output logic [9:0] pairs, output int len, output int gap);
        int   r;
        int   e;
        logic prev;
        r = 0; prev = 1'b0; pairs = '0; len = 0; gap = 0; e = -1;
        for (int c = 0; c < cap_n; c++) begin
            if (cap_fr[c] && !prev) r++;
            if (cap_fr[c] && r == run) begin
                pairs = {pairs[7:0], cap_d0[c], cap_d1[c]};
                len++;
                e = c;
            end
            prev = cap_fr[c];
        end
        if (e >= 0) begin
            for (int c = e + 1; c < cap_n && !cap_cd0[c] && !cap_fr[c]; c++) gap++;
        end
    endtask

    // Frame-level model advances on every active edge.
    initial forever begin
        @(posedge clk);
        ma = step(ma, rst, va, da, 2, 1, 1'b0);
        mb = step(mb, rst, vb, db, 0, 0, 1'b1);
    end

    // Every cycle compare both sequencers with the model, and the falling-edge ODDR output.
    initial forever begin
        @(negedge clk);
        if (chk_en) begin
            check("model_a", {24'd0, a_d0, a_d1, a_fr, a_bz, a_cd0, a_cd1, a_ce, a_rdy}, {24'd0, ma.exp});
            check("model_b", {24'd0, b_d0, b_d1, b_fr, b_bz, b_cd0, b_cd1, b_ce, b_rdy}, {24'd0, mb.exp});
            #1;
            check("oddr_fall", {30'd0, a_ddr_q, a_clk_q}, {30'd0, ma.exp.d1, 1'b0});
        end
    end

    initial begin
        vec_t       tbl[$];
        vec_t       e;
        logic [9:0] p1, p2;
        int         l1, l2, g1, g2, bad, nb, nc;

        rst = 1'b1; va = 1'b0; vb = 1'b0; da = 8'h00; db = 8'h00;
        tick();
        chk_en = 1'b1;
        repeat (2) tick();
        check("reset_state", {24'd0, a_d0, a_d1, a_ce, a_fr, a_bz, a_cd0, a_cd1, a_rdy}, 32'h20);
        rst = 1'b0;
        tick();
        check("ready_after_reset", {31'd0, a_rdy}, 32'd1);

        bad = 0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if ({a_d0, a_d1, a_cd0, a_cd1, a_rdy, a_bz} !== 6'b000010) bad++;
        end
        check("idle_hold", bad, 0);

        tbl.push_back('{1'b1, 8'hA5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0});
        for (int i = 0; i < 2; i++) tbl.push_back('{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0});
        for (int i = 0; i < 2; i++) tbl.push_back('{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0});
        for (int i = 0; i < 2; i++) tbl.push_back('{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0});
`ifdef DDR_TX_PARITY_EN
        tbl.push_back('{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0});
`endif
        tbl.push_back('{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1});
        tbl.push_back('{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1});
        for (int i = 0; i < tbl.size(); i++) begin
            e = tbl[i];
            va = e.v; da = e.d;
            tick();
            check($sformatf("table_a5_%0d", i), {26'd0, a_d0, a_d1, a_fr, a_bz, a_cd0, a_rdy},
                  {26'd0, e.d0, e.d1, e.fr, e.bz, e.cd0, e.rdy});
        end
        va = 1'b0;

        wait_ready_a();
        capture(8'h3C, 8'hC3, 2);
        run_info(1, p1, l1, g1);
        run_info(2, p2, l2, g2);
        check("b2b_pairs_3c", p1, exp_pairs(8'h3C));
        check("b2b_pairs_c3", p2, exp_pairs(8'hC3));
        check("b2b_len", l1, 4 + PAR);
        check("b2b_gap", g1, 2);

        wait_ready_a();
        capture(8'hA5, 8'hA4, 2);
        run_info(1, p1, l1, g1);
        run_info(2, p2, l2, g2);
        check("a5_frame_len", l1, 4 + PAR);
        check("a4_frame_len", l2, 4 + PAR);
        check("a5_last_pair", p1[1:0], 2'b01);
`ifdef DDR_TX_PARITY_EN
        check("a4_last_pair", p2[1:0], 2'b10);
`else
        check("a4_last_pair", p2[1:0], 2'b00);
`endif

        wait_ready_a();
        va = 1'b1; da = 8'hFF;
        tick();
        va = 1'b0;
        repeat (5) tick();
        check("mid_frame_shift", {29'd0, a_fr, a_d0, a_d1}, 32'd7);
        rst = 1'b1;
        tick();
        check("mid_frame_reset", {24'd0, a_d0, a_d1, a_fr, a_bz, a_cd0, a_cd1, a_ce, a_rdy}, 32'h02);
        rst = 1'b0;
        tick();
        check("ready_after_midreset", {31'd0, a_rdy}, 32'd1);
        capture(8'h0F, 8'h00, 1);
        run_info(1, p1, l1, g1);
        check("after_reset_0f", p1, exp_pairs(8'h0F));

        nc = 0;
        while (!b_rdy && nc < 50) begin
            tick();
            nc++;
        end
        check("wait_ready_b", {31'd0, b_rdy}, 32'd1);
        vb = 1'b1; db = 8'h81;
        tick();
        vb = 1'b0;
        nb = 0; nc = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (i == 0) check("nopre_first_shift", {29'd0, b_fr, b_d0, b_d1}, 32'd6);
            if (b_bz) nb++;
            if (b_cd0) nc++;
        end
        check("nopre_busy_cycles", nb, 4 + PAR);
        check("nopre_clk_cycles", nc, 4 + PAR);

        for (int i = 0; i < 3000; i++) begin
            rst = ($urandom_range(0, 99) == 0);
            va  = 1'($urandom_range(0, 1));
            vb  = 1'($urandom_range(0, 1));
            da  = 8'($urandom);
            db  = 8'($urandom);
            tick();
        end
        rst = 1'b0; va = 1'b0; vb = 1'b0;
        repeat (20) tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/ddr_tx_sequencer.md
Name: ddr_tx_sequencer

Overview:
- Single-lane DDR transmit sequencer that drives the D0/D1/CE inputs of an ODDR2 data primitive and a companion ODDR2 used as a forwarded clock.
- Accepts parallel words over a valid/ready handshake and emits a preamble, then the word two bits per clock, MSB first, then an inter-frame gap.
- Sits between a TX FIFO and the I/O-tile DDR output registers.
- All outputs are registered, so the ODDR2 inputs see clean, glitch-free levels.

Parameters:
DATA_WIDTH, 16, bits per word; must be even and >= 2.
PREAMBLE_CYCLES, 2, clock cycles of preamble before data; 0 skips the preamble.
GAP_CYCLES, 1, idle cycles after a frame before the next word is accepted; 0 allows back-to-back frames with only the IDLE cycle between them.
IDLE_LEVEL, 1'b0, line level driven on ddr_d0/ddr_d1 when no frame is active.

Ports:
clk  input  1  system clock; drives the ODDR2 C0 pin, with inverted clk on C1.
reset  input  1  synchronous, active-high reset.
in_data  input  DATA_WIDTH  word to transmit.
in_valid  input  1  in_data is valid.
in_ready  output  1  sequencer can accept a word.
ddr_d0  output  1  to data ODDR2 D0; bit driven in the first half of the cycle.
ddr_d1  output  1  to data ODDR2 D1; bit driven in the second half of the cycle.
ddr_ce  output  1  to data ODDR2 CE.
clk_d0  output  1  to forwarded-clock ODDR2 D0.
clk_d1  output  1  to forwarded-clock ODDR2 D1.
frame  output  1  high while data or parity bits are on ddr_d0/ddr_d1.
busy  output  1  high in every state except IDLE.

Behaviour:
- Reset values:
  - in_ready = 0, frame = 0, busy = 0, clk_d0 = 0, clk_d1 = 0.
  - ddr_d0 = ddr_d1 = IDLE_LEVEL; ddr_ce = 1.
  - State = IDLE; shift register and counter = 0.
- in_ready = (state == IDLE) && !reset. A word is accepted on a clk edge where in_valid && in_ready; in_data is captured into the shift register on that edge.
- State machine:
  - IDLE -> PREAMBLE on accept, or -> SHIFT if PREAMBLE_CYCLES == 0.
  - PREAMBLE lasts PREAMBLE_CYCLES cycles, then -> SHIFT.
  - SHIFT lasts DATA_WIDTH/2 cycles, then -> PARITY if the feature is enabled, else -> GAP. If GAP_CYCLES == 0, go to IDLE instead of GAP.
  - PARITY lasts 1 cycle, then -> GAP (or -> IDLE if GAP_CYCLES == 0).
  - GAP lasts GAP_CYCLES cycles, then -> IDLE.
- Latency: accept at edge N; the registered outputs show the first PREAMBLE (or SHIFT) cycle after edge N+1.
- Output levels per state:
  - PREAMBLE: ddr_d0 = 1, ddr_d1 = 0.
  - SHIFT: ddr_d0 = sr[DATA_WIDTH-1], ddr_d1 = sr[DATA_WIDTH-2]; the shift register shifts left by 2 each cycle with zero fill.
  - IDLE and GAP: ddr_d0 = ddr_d1 = IDLE_LEVEL.
- Forwarded clock: clk_d0 = 1, clk_d1 = 0 in PREAMBLE, SHIFT and PARITY; otherwise 0/0, so the forwarded clock is parked low.
- frame: high exactly during SHIFT and PARITY.
- Counter: $clog2 of max(PREAMBLE_CYCLES, DATA_WIDTH/2, GAP_CYCLES) + 1 bits wide. Loaded with the state length minus 1 on entry and decremented to 0; it never wraps.
- No input is sampled outside IDLE. in_valid held high through a frame is not accepted until the next IDLE cycle.
- Reset mid-frame:
  - All outputs take their reset values on the next edge.
  - The in-flight word is dropped and no partial frame is resumed.

Optional Feature:
- Macro: DDR_TX_PARITY_EN.
- Defined:
  - A PARITY cycle is appended after SHIFT: ddr_d0 = even parity (XOR) of the accepted word, ddr_d1 = inverse of ddr_d0.
  - frame and the forwarded clock stay active for that cycle.
  - A parity register latches the XOR at accept.
- Undefined: the PARITY state and the parity register do not exist; SHIFT goes directly to GAP or IDLE.

Decomposition:
- Shared package ddr_tx_pkg holds:
  - the state enum (IDLE, PREAMBLE, SHIFT, PARITY, GAP);
  - the preamble bit-pair constants;
  - the counter-width function.
- One sub-module, ddr_tx_oddr_pair: instantiates the data and clock ODDR2s with C0 = clk, C1 = ~clk, R = S = 0. It lives in the top-level I/O wrapper, not inside the sequencer, so the sequencer stays simulatable without unisims.

Test Plan:
1. DATA_WIDTH=8, PREAMBLE_CYCLES=2, GAP_CYCLES=1, accept 0xA5:
   - Expect 2 cycles of (d0,d1)=(1,0) with frame=0.
   - Then (1,0),(1,0),(0,1),(0,1) with frame=1.
   - Then 1 gap cycle at IDLE_LEVEL, and in_ready returns high on cycle 8 after accept.
2. in_valid held high with words 0x3C, 0xC3: two frames separated by exactly GAP_CYCLES + 1 idle cycles; the second frame's pairs are (1,1),(0,0),(0,0),(1,1).
3. Assert reset during the third SHIFT cycle of 0xFF:
   - Next edge: ddr_d0 = ddr_d1 = 0, frame = 0, busy = 0, clk_d0 = 0; in_ready = 1 one cycle after reset is released.
   - A subsequent word 0x0F is sent complete.
4. PREAMBLE_CYCLES=0, GAP_CYCLES=0, accept 0x81: SHIFT starts the first cycle after accept; busy is high for exactly 4 cycles; clk_d0 is high for exactly 4 cycles.
5. With DDR_TX_PARITY_EN, send 0xA5 then 0xA4:
   - The 0xA5 frame ends with (0,1); the 0xA4 frame ends with (1,0).
   - frame is high for 5 cycles in each frame.
6. in_valid=0 for 100 cycles after reset: outputs hold IDLE_LEVEL, clk_d0 = clk_d1 = 0, in_ready = 1, busy = 0 throughout.
